mux6_rr_scheduler: RTL
======================

// Module: mux6_rr_scheduler
// PURPOSE
//   Round-robin scheduler that shares one 6:1 mux output path among six requesters.
//   Drives the 3-bit mux select and a one-hot grant vector.
//   Enforces a per-grant hold limit and inserts one dead (turnaround) cycle between grants.
//   Sits directly in front of the Sel input of the 6:1 select datapath.
// PARAMETERS
//   MAX_HOLD  4  max consecutive GRANT cycles per grant, range 0..255; 0 = unlimited
// PORTS
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous, active-high reset
//   req      in   6  request per source; bit i held high while source i wants the path
//   grant    out  6  one-hot grant, registered; 0 when nobody owns the path
//   sel      out  3  mux select, registered; index of current/last grantee, never 6 or 7
//   valid    out  1  high iff grant != 0
//   preempt  out  1  one-cycle pulse: grant was removed by the MAX_HOLD limit
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, grant=0, sel=0, valid=0, preempt=0, hold_cnt=0, last=5.
//     Last=5 gives source 0 top priority after reset. Reset mid-grant drops grant in the same cycle.
//   - States: IDLE, GRANT, GAP. All outputs registered; no comb path req->grant.
//   - Winner = first i with req[i]=1, searching last+1, last+2, ... mod 6. The search wraps and includes last itself (searched last).
//   - IDLE: if |req at edge -> GRANT. On that edge: grant=onehot(winner), sel=winner, valid=1, hold_cnt=1.
//     Otherwise stay in IDLE. Latency: req high before edge N -> grant visible after edge N.
//   - GRANT, owner k. At each edge, evaluate in this priority:
//     a) req[k]=0 (release): -> GAP, grant=0, valid=0, last=k, preempt=0.
//     b) MAX_HOLD!=0 and hold_cnt==MAX_HOLD: -> GAP, grant=0, valid=0, last=k, preempt=1 for one cycle.
//     c) otherwise stay in GRANT, hold_cnt++ (8-bit). hold_cnt saturates at 255 when MAX_HOLD=0.
//   - GAP: exactly one cycle with grant=0. Arbitrates like IDLE: if |req -> GRANT with winner.
//     If no request -> IDLE. preempt returns to 0.
//   - Handover timing: owner active for hold cycles, then 1 dead cycle, then the next owner.
//     With MAX_HOLD=M and all requesting, the period is (M+1) cycles per source.
//   - sel holds its value through GAP and IDLE; it changes only when a new grant is issued.
//   - A source that drops req while not granted is ignored. Requests have no memory; a pulse that
//     is low on the arbitration edge is lost.
//   - A sole requester that is released or preempted is re-granted after the GAP.
//   - Invariants: grant is one-hot or zero; valid == |grant; sel < 6; preempt never high while valid=1.
// TESTING
//   T1 reset: in GRANT with sel=3, assert rst mid-cycle -> grant=0, valid=0, sel=0, preempt=0 immediately.
//      Release rst, req=000001 -> grant=000001 after the next edge.
//   T2 single: req=000100 for 3 cycles then 0 (MAX_HOLD=4) -> grant=000100, sel=2 for 3 cycles.
//      Then one GAP cycle, then IDLE. preempt stays 0.
//   T3 fairness: req=111111 constant, MAX_HOLD=4 -> owners 0,1,2,3,4,5,0,... each for 4 cycles.
//      One dead cycle at each handover, preempt pulses at each handover.
//   T4 wrap: last=4, req=100001 -> grant 5 first. After release, grant 0 (wraps past 5).
//   T5 unlimited: MAX_HOLD=0, req=001000 held 300 cycles -> grant=001000 throughout.
//      hold_cnt saturates at 255, preempt never asserts.
//   T6 release with contender: owner 3 drops req after 2 cycles while req[5]=1 -> GAP cycle, then grant=100000, sel=5.

Source files
------------

// File: rtl/mux6_rr_scheduler.sv
// mux6_rr_scheduler
//   Round-robin scheduler for one shared 6:1 mux output path. Every grant is
//   followed by one dead (turnaround) cycle, and a grant can be cut short after
//   MAX_HOLD cycles (MAX_HOLD = 0 means no limit).
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   req      [5:0] per-source request, held high while the source wants the path
//   grant    [5:0] registered one-hot grant, zero when nobody owns the path
//   sel      [2:0] registered mux select; index of the current/last grantee
//   valid    high iff grant is nonzero
//   preempt  one-cycle pulse when a grant was removed by the hold limit
module mux6_rr_scheduler #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req,
  output logic [5:0] grant,
  output logic [2:0] sel,
  output logic       valid,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam bit         LIMITED    = (MAX_HOLD != 0);

  state_t     state, state_n;
  logic [5:0] grant_n;
  logic [2:0] sel_n;
  logic       valid_n;
  logic       preempt_n;
  logic [7:0] hold_cnt, hold_n;
  logic [2:0] last, last_n;

  logic [2:0] winner;
  logic       owner_req;

  // Search last+1 .. last+6 (mod 6); last itself is considered last of all.
  always_comb begin
    logic [3:0] pos;
    logic       found;
    winner = last;
    found  = 1'b0;
    for (int unsigned i = 1; i <= 6; i++) begin
      pos = 4'(last) + 4'(i);
      if (pos >= 4'd6) pos = pos - 4'd6;
      if (!found && req[pos[2:0]]) begin
        winner = pos[2:0];
        found  = 1'b1;
      end
    end
  end

  // grant is one-hot, so this picks out the owner's own request bit.
  assign owner_req = |(req & grant);

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    sel_n     = sel;
    valid_n   = valid;
    preempt_n = 1'b0;
    hold_n    = hold_cnt;
    last_n    = last;
    unique case (state)
      IDLE, GAP: begin
        if (|req) begin
          state_n = GRANT;
          grant_n = 6'b000001 << winner;
          sel_n   = winner;
          valid_n = 1'b1;
          hold_n  = 8'd1;
        end else begin
          state_n = IDLE;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_n = GAP;
          grant_n = '0;
          valid_n = 1'b0;
          last_n  = sel;
        end else if (LIMITED && hold_cnt == HOLD_LIMIT) begin
          state_n   = GAP;
          grant_n   = '0;
          valid_n   = 1'b0;
          last_n    = sel;
          preempt_n = 1'b1;
        end else if (hold_cnt != 8'hFF) begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
      last     <= 3'd5;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      sel      <= sel_n;
      valid    <= valid_n;
      preempt  <= preempt_n;
      hold_cnt <= hold_n;
      last     <= last_n;
    end
  end

endmodule
